// File: rtl/his_peak_reader_pkg.sv
// Shared constants and state encoding for the histogram peak reader.
package his_peak_reader_pkg;

  localparam int NB        = 6;
  localparam int BIN_NUM   = 1 << NB;
  localparam int PIXEL_NUM = 4;
  localparam int PIX_W     = 2;
  localparam int CNT_W     = 16;
  localparam int MIN_CNT   = 2;
  localparam int ADDR_W    = PIX_W + NB;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A peak counts as a hit once it reaches the minimum count.
  function automatic logic is_hit(input logic [CNT_W-1:0] cnt);
    return cnt >= CNT_W'(MIN_CNT);
  endfunction

endpackage

// File: rtl/his_peak_reader_argmax_acc.sv
// Running argmax over one pixel histogram. max_bin/max_cnt already include
// the sample presented this cycle, so the owner can capture the final
// result on the same edge that retires the last bin.
module his_argmax_acc
  import his_peak_reader_pkg::*;
(
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             in_valid,
  input  logic [NB-1:0]    in_bin,
  input  logic [CNT_W-1:0] in_cnt,
  output logic [NB-1:0]    max_bin,
  output logic [CNT_W-1:0] max_cnt
);

  logic [NB-1:0]    bin_q;
  logic [CNT_W-1:0] cnt_q;
  logic             take;

  // Strictly greater only, so ties keep the lowest bin seen first.
  assign take    = in_valid && (in_cnt > cnt_q);
  assign max_bin = take ? in_bin : bin_q;
  assign max_cnt = take ? in_cnt : cnt_q;

  // Running max register, cleared at every pixel start.
  always_ff @(posedge clk) begin
    if (res || start) begin
      bin_q <= '0;
      cnt_q <= '0;
    end else if (take) begin
      bin_q <= in_bin;
      cnt_q <= in_cnt;
    end
  end

endmodule

// File: rtl/his_peak_reader.sv
// Read side of the ping-pong histogram RAM: scans each pixel's histogram,
// clears every bin behind the read, and emits one peak record per pixel.
module his_peak_reader
  import his_peak_reader_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              his_done,
  input  logic              his_sel,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [CNT_W-1:0]  rd_data,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              peak_valid,
  input  logic              peak_ready,
  output logic [PIX_W-1:0]  peak_pix,
  output logic [NB-1:0]     peak_bin,
  output logic [CNT_W-1:0]  peak_cnt,
  output logic              peak_hit,
  output logic              busy,
  output logic              overrun
);

  state_t            state;
  logic [PIX_W-1:0]  pix_q;
  logic [NB-1:0]     bin_q;
  logic              last_pix;
  logic              acc_start;

  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;

  logic [NB-1:0]     max_bin;
  logic [CNT_W-1:0]  max_cnt;

  assign last_pix  = (pix_q == PIX_W'(PIXEL_NUM - 1));
  assign acc_start = ((state == ST_IDLE) && his_done) ||
                     ((state == ST_OUT) && peak_ready && !last_pix);

  // Clearing the address just read keeps clr_en tied to a prior rd_en.
  assign clr_en   = vld_p1;
  assign clr_addr = addr_p1;

  // ---- stage p1: read data returns; compare and clear that address ----
  // Delay the read strobe/address by one cycle to line up with rd_data.
  always_ff @(posedge clk) begin
    if (res) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
    end else begin
      vld_p1  <= rd_en;
      addr_p1 <= rd_addr;
    end
  end

  his_argmax_acc u_acc (
    .clk      (clk),
    .res      (res),
    .start    (acc_start),
    .in_valid (vld_p1),
    .in_bin   (addr_p1[NB-1:0]),
    .in_cnt   (rd_data),
    .max_bin  (max_bin),
    .max_cnt  (max_cnt)
  );

  // Scan control: address generation, record handshake and status flags.
  always_ff @(posedge clk) begin
    if (res) begin
      state      <= ST_IDLE;
      pix_q      <= '0;
      bin_q      <= '0;
      rd_en      <= 1'b0;
      rd_bank    <= 1'b0;
      rd_addr    <= '0;
      peak_valid <= 1'b0;
      peak_pix   <= '0;
      peak_bin   <= '0;
      peak_cnt   <= '0;
      peak_hit   <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // A new bank arriving before the scan finishes is dropped, but flagged.
      if (his_done && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (his_done) begin
            rd_bank <= his_sel;
            pix_q   <= '0;
            bin_q   <= '0;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            busy    <= 1'b1;
            state   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bin_q == NB'(BIN_NUM - 1)) begin
            rd_en <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            bin_q   <= bin_q + NB'(1);
            rd_addr <= {pix_q, bin_q + NB'(1)};
          end
        end
        ST_DRAIN: begin
          peak_pix   <= pix_q;
          peak_bin   <= max_bin;
          peak_cnt   <= max_cnt;
          peak_hit   <= is_hit(max_cnt);
          peak_valid <= 1'b1;
          state      <= ST_OUT;
        end
        ST_OUT: begin
          if (peak_ready) begin
            peak_valid <= 1'b0;
            if (!last_pix) begin
              pix_q   <= pix_q + PIX_W'(1);
              bin_q   <= '0;
              rd_en   <= 1'b1;
              rd_addr <= {pix_q + PIX_W'(1), NB'(0)};
              state   <= ST_SCAN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_his_peak_reader.sv
// Bench for his_peak_reader: RAM model, table of per-pixel histograms with
// expected peaks, scoreboard of peak records, and multi-cycle corner cases.
module tb_his_peak_reader;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        his_done = 1'b0;
  logic        his_sel = 1'b0;
  logic        rd_en;
  logic        rd_bank;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = 16'd0;
  logic        clr_en;
  logic [7:0]  clr_addr;
  logic        peak_valid;
  logic        peak_ready = 1'b1;
  logic [1:0]  peak_pix;
  logic [5:0]  peak_bin;
  logic [15:0] peak_cnt;
  logic        peak_hit;
  logic        busy;
  logic        overrun;

  his_peak_reader dut (
    .clk(clk), .res(res), .his_done(his_done), .his_sel(his_sel),
    .rd_en(rd_en), .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_data(rd_data),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_pix(peak_pix),
    .peak_bin(peak_bin), .peak_cnt(peak_cnt), .peak_hit(peak_hit),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // RAM model: registered read, write-zero clear, bench load and wipe port.
  logic [15:0] mem [0:1][0:255];
  logic        ld_en = 1'b0;
  logic        ld_wipe = 1'b0;
  logic        ld_bank = 1'b0;
  logic [7:0]  ld_addr = 8'd0;
  logic [15:0] ld_val = 16'd0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_bank][rd_addr];
    if (clr_en) mem[rd_bank][clr_addr] <= 16'd0;
    if (ld_en) mem[ld_bank][ld_addr] <= ld_val;
    if (ld_wipe) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 256; a++)
          mem[b][a] <= 16'd0;
    end
  end

  typedef struct packed {
    logic [1:0]  pix;
    logic [5:0]  bin;
    logic [15:0] cnt;
    logic        hit;
  } rec_t;

  typedef struct {
    int bin_a; int val_a; int bin_b; int val_b; int bg;
    int e_bin; int e_cnt; int e_hit;
  } vec_t;

  vec_t vecs [8];
  rec_t exp_q [$];
  logic exp_bank = 1'b0;
  int   rd_cnt = 0;
  int   n_rec = 0;

  // Monitor: bank of every read, reads per pixel, and record scoreboard.
  always @(negedge clk) begin
    if (res) begin
      rd_cnt = 0;
    end else begin
      if (rd_en) begin
        rd_cnt++;
        chk("rd_bank", 64'(rd_bank), 64'(exp_bank));
      end
      if (peak_valid && peak_ready) begin
        n_rec++;
        chk("reads_per_pixel", 64'(rd_cnt), 64'd64);
        rd_cnt = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_record", 64'd1, 64'd0);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          chk("peak_pix", 64'(peak_pix), 64'(r.pix));
          chk("peak_bin", 64'(peak_bin), 64'(r.bin));
          chk("peak_cnt", 64'(peak_cnt), 64'(r.cnt));
          chk("peak_hit", 64'(peak_hit), 64'(r.hit));
        end
      end
    end
  end

  task automatic load_pixel(input int bank, input int pix, input vec_t v);
    for (int b = 0; b < 64; b++) begin
      @(posedge clk); #1;
      ld_en   = 1'b1;
      ld_bank = bank[0];
      ld_addr = {pix[1:0], b[5:0]};
      ld_val  = (b == v.bin_a) ? 16'(v.val_a) :
                (b == v.bin_b) ? 16'(v.val_b) : 16'(v.bg);
    end
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic write_word(input int bank, input int addr, input int val);
    @(posedge clk); #1;
    ld_en = 1'b1; ld_bank = bank[0]; ld_addr = addr[7:0]; ld_val = val[15:0];
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic push_exp(input int first);
    for (int p = 0; p < 4; p++) begin
      rec_t r;
      r.pix = 2'(p);
      r.bin = 6'(vecs[first + p].e_bin);
      r.cnt = 16'(vecs[first + p].e_cnt);
      r.hit = (vecs[first + p].e_hit != 0);
      exp_q.push_back(r);
    end
  endtask

  task automatic pulse_done(input logic sel);
    @(posedge clk); #1;
    his_done = 1'b1; his_sel = sel;
    @(posedge clk); #1;
    his_done = 1'b0; his_sel = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    chk("scan_completes", 64'(busy), 64'd0);
  endtask

  task automatic chk_bank_zero(input int bank);
    int nz = 0;
    for (int a = 0; a < 256; a++)
      if (mem[bank][a] != 16'd0) nz++;
    chk("bank_cleared", 64'(nz), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rd_en, rd_bank, rd_addr, clr_en, clr_addr, peak_valid, peak_pix,
                peak_bin, peak_cnt, peak_hit, busy, overrun});
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rec_t held;
    int   n;

    //          bin_a val_a  bin_b val_b  bg     e_bin e_cnt  e_hit
    vecs[0] = '{37,   9,     -1,   0,     1,     37,   9,     1};
    vecs[1] = '{5,    7,     50,   7,     0,     5,    7,     1};
    vecs[2] = '{-1,   0,     -1,   0,     0,     0,    0,     0};
    vecs[3] = '{63,   65535, -1,   0,     0,     63,   65535, 1};
    vecs[4] = '{0,    1,     -1,   0,     0,     0,    1,     0};
    vecs[5] = '{10,   2,     20,   1,     0,     10,   2,     1};
    vecs[6] = '{1,    65535, 63,   65535, 100,   1,    65535, 1};
    vecs[7] = '{0,    500,   1,    501,   3,     1,    501,   1};

    // Reset state
    ld_wipe = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ld_wipe = 1'b0;
    res = 1'b0;
    @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);

    // Bank 0 with back-pressure on the first record
    for (int p = 0; p < 4; p++) load_pixel(0, p, vecs[p]);
    push_exp(0);
    exp_bank = 1'b0;
    peak_ready = 1'b0;
    pulse_done(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!peak_valid && n < 300);
    chk("first_record_valid", 64'(peak_valid), 64'd1);
    held = {peak_pix, peak_bin, peak_cnt, peak_hit};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_record_stable", 64'({peak_valid, peak_pix, peak_bin, peak_cnt, peak_hit}),
          64'({1'b1, held}));
      chk("stall_no_read", 64'(rd_en), 64'd0);
    end
    @(posedge clk); #1;
    peak_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rd_en && n < 10);
    chk("resume_addr", 64'({rd_en, rd_addr}), 64'({1'b1, 8'h40}));
    wait_idle();
    chk_bank_zero(0);
    chk("no_overrun", 64'(overrun), 64'd0);

    // Bank 1 with an overlapping his_done
    write_word(0, 3, 5);
    for (int p = 0; p < 4; p++) load_pixel(1, p, vecs[4 + p]);
    push_exp(4);
    exp_bank = 1'b1;
    n = n_rec;
    pulse_done(1'b1);
    repeat (19) @(posedge clk);
    pulse_done(1'b0);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("records_per_scan", 64'(n_rec - n), 64'd4);
    chk("stays_idle", 64'(busy), 64'd0);
    chk("overrun_set", 64'(overrun), 64'd1);
    chk_bank_zero(1);
    chk("other_bank_untouched", 64'(mem[0][3]), 64'd5);
    write_word(0, 3, 0);

    // Reset in the middle of pixel 2
    for (int p = 0; p < 4; p++) load_pixel(0, p, vecs[p]);
    push_exp(0);
    exp_bank = 1'b0;
    pulse_done(1'b0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(rd_en && rd_addr == 8'h8A) && n < 1000);
    chk("reached_pix2_bin10", 64'({rd_en, rd_addr}), 64'({1'b1, 8'h8A}));
    res = 1'b1;
    @(posedge clk); #1;
    chk("midscan_reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    res = 1'b0;
    chk("records_before_reset", 64'(exp_q.size()), 64'd2);
    exp_q.delete();

    // Full scan after reset
    for (int p = 0; p < 4; p++) load_pixel(0, p, vecs[p]);
    push_exp(0);
    pulse_done(1'b0);
    wait_idle();
    chk_bank_zero(0);
    chk("overrun_after_reset", 64'(overrun), 64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
